multi_range_tracker: RTL and testbench

MULTI_RANGE_TRACKER -- requirements
Module: multi_range_tracker

---
 rtl/multi_range_tracker_pkg.sv | 30 +++
 rtl/range_lane.sv | 67 ++++++
 rtl/multi_range_tracker.sv | 147 ++++++++++++++
 tb/tb_multi_range_tracker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_range_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_range_tracker_pkg
// Description : Shared FSM state encoding and per-channel accumulator reset
//               values for the multi-channel min/max/count tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_range_tracker_pkg;

  // Controller states. Encoding width is explicit so it is stable in netlists.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REPORT  = 2'd2
  } state_e;

  // Per-channel reset values, replicated to the data/count width at use site.
  // min starts at all-ones so the first sample always wins the comparison;
  // max starts at zero for the same reason.
  localparam logic LANE_MIN_RST_BIT = 1'b1;
  localparam logic LANE_MAX_RST_BIT = 1'b0;
  localparam logic LANE_CNT_RST_BIT = 1'b0;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/range_lane.sv
`default_nettype none
// ============================================================================
// Module      : range_lane
// Description : One channel's running minimum, maximum and saturating sample
//               count. clear_i reloads the reset values; upd_i folds in data_i.
// Revision    : 1.0 - initial release
// ============================================================================
module range_lane
  import multi_range_tracker_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              upd_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] min_o,
  output logic [DATA_W-1:0] max_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam logic [DATA_W-1:0] MIN_RST = {DATA_W{LANE_MIN_RST_BIT}};
  localparam logic [DATA_W-1:0] MAX_RST = {DATA_W{LANE_MAX_RST_BIT}};
  localparam logic [CNT_W-1:0]  CNT_RST = {CNT_W{LANE_CNT_RST_BIT}};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state: clear has priority over a sample so a window always starts fresh.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      min_d = MIN_RST;
      max_d = MAX_RST;
      cnt_d = CNT_RST;
    end else if (upd_i) begin
      if (data_i < min_q) min_d = data_i;
      if (data_i > max_q) max_d = data_i;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Accumulator registers with asynchronous reset to the empty-channel values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      min_q <= MIN_RST;
      max_q <= MAX_RST;
      cnt_q <= CNT_RST;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      cnt_q <= cnt_d;
    end
  end

  assign min_o   = min_q;
  assign max_o   = max_q;
  assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/multi_range_tracker.sv
`default_nettype none
// ============================================================================
// Module      : multi_range_tracker
// Description : Collects unsigned samples per channel between go and finish,
//               then reports min/max/range/count one channel per cycle.
//               Protocol violations raise a sticky error flag and are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_range_tracker
  import multi_range_tracker_pkg::*;
#(
  parameter  int DATA_W   = 10,
  parameter  int CHANNELS = 4,
  parameter  int CNT_W    = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              go,
  input  logic              finish,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_range,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last,
  output logic              busy,
  output logic              error
);

  localparam logic [CH_W:0]   CH_LIMIT = (CH_W+1)'(CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CHANNELS - 1);

  state_e            state_q;
  logic [CH_W-1:0]   rpt_ch_q;
  logic              error_q;

  logic              w_ch_ok;
  logic              w_go_ok;
  logic              w_fin_ok;
  logic              w_acc;
  logic              w_viol;
  logic [CHANNELS-1:0] w_upd;

  logic [DATA_W-1:0] w_min [CHANNELS];
  logic [DATA_W-1:0] w_max [CHANNELS];
  logic [CNT_W-1:0]  w_cnt [CHANNELS];

  // Decode legal requests and every protocol violation for this cycle.
  always_comb begin
    w_ch_ok  = ({1'b0, in_ch} < CH_LIMIT);
    w_go_ok  = (state_q == ST_IDLE) && go && !finish;
    w_fin_ok = (state_q == ST_COLLECT) && finish && !go;
    w_acc    = (state_q == ST_COLLECT) && in_valid && w_ch_ok;
    w_viol   = (go && finish)
             || (finish && (state_q == ST_IDLE))
             || (go && (state_q != ST_IDLE))
             || (in_valid && (state_q != ST_COLLECT))
             || (in_valid && !w_ch_ok);
  end

  // Controller FSM: window sequencing, report channel pointer and sticky error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rpt_ch_q <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_go_ok) state_q <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (w_fin_ok) begin
            state_q  <= ST_REPORT;
            rpt_ch_q <= '0;
          end
        end
        ST_REPORT: begin
          if (rpt_ch_q == LAST_CH) begin
            state_q  <= ST_IDLE;
            rpt_ch_q <= '0;
          end else begin
            rpt_ch_q <= rpt_ch_q + CH_W'(1);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          rpt_ch_q <= '0;
        end
      endcase
      // A violation in the same cycle as an accepted go still leaves the flag set.
      if (w_viol)       error_q <= 1'b1;
      else if (w_go_ok) error_q <= 1'b0;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    assign w_upd[k] = w_acc && (in_ch == CH_W'(k));

    range_lane #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clock   (clock),
      .reset_n (reset_n),
      .clear_i (w_go_ok),
      .upd_i   (w_upd[k]),
      .data_i  (in_data),
      .min_o   (w_min[k]),
      .max_o   (w_max[k]),
      .count_o (w_cnt[k])
    );
  end

  // Report beat: a pure decode of registered state so the beat for channel k
  // appears k+1 cycles after finish and includes a sample taken with finish.
  always_comb begin
    out_valid = 1'b0;
    out_ch    = '0;
    out_min   = '0;
    out_max   = '0;
    out_range = '0;
    out_count = '0;
    out_last  = 1'b0;
    if (state_q == ST_REPORT) begin
      out_valid = 1'b1;
      out_ch    = rpt_ch_q;
      out_count = w_cnt[rpt_ch_q];
      out_last  = (rpt_ch_q == LAST_CH);
      if (w_cnt[rpt_ch_q] != '0) begin
        out_min   = w_min[rpt_ch_q];
        out_max   = w_max[rpt_ch_q];
        out_range = w_max[rpt_ch_q] - w_min[rpt_ch_q];
      end
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_range_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_range_tracker
// Description : Directed self-checking bench. dut_a uses the default sizing;
//               dut_b (3 channels, 2-bit count) shares the stimulus to reach
//               count saturation and an out-of-range channel index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_range_tracker;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       go      = 1'b0;
  logic       finish  = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_ch   = 2'd0;
  logic [9:0] in_data = 10'd0;

  logic       a_out_valid, a_out_last, a_busy, a_error;
  logic [1:0] a_out_ch;
  logic [9:0] a_out_min, a_out_max, a_out_range;
  logic [7:0] a_out_count;

  logic       b_out_valid, b_out_last, b_busy, b_error;
  logic [1:0] b_out_ch;
  logic [9:0] b_out_min, b_out_max, b_out_range;
  logic [1:0] b_out_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  multi_range_tracker #(.DATA_W(10), .CHANNELS(4), .CNT_W(8)) dut_a (
    .clock(clock), .reset_n(reset_n), .go(go), .finish(finish),
    .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .out_valid(a_out_valid), .out_ch(a_out_ch), .out_min(a_out_min),
    .out_max(a_out_max), .out_range(a_out_range), .out_count(a_out_count),
    .out_last(a_out_last), .busy(a_busy), .error(a_error)
  );

  multi_range_tracker #(.DATA_W(10), .CHANNELS(3), .CNT_W(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .go(go), .finish(finish),
    .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .out_valid(b_out_valid), .out_ch(b_out_ch), .out_min(b_out_min),
    .out_max(b_out_max), .out_range(b_out_range), .out_count(b_out_count),
    .out_last(b_out_last), .busy(b_busy), .error(b_error)
  );

  // Beat vectors: {valid, ch, min, max, range, count, last}
  wire [41:0] a_beat = {a_out_valid, a_out_ch, a_out_min, a_out_max, a_out_range, a_out_count, a_out_last};
  wire [35:0] b_beat = {b_out_valid, b_out_ch, b_out_min, b_out_max, b_out_range, b_out_count, b_out_last};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_tests++;
    if ({a_busy, a_error, a_out_valid, a_out_last} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_a flags got %b want 0000", {a_busy, a_error, a_out_valid, a_out_last});
    end
    n_tests++;
    if (a_beat !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_a beat got %h want 0", a_beat);
    end
    reset_n = 1'b1;
    tick();
    n_tests++;
    if ({a_busy, a_error, b_busy, b_error} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release flags got %b want 0000", {a_busy, a_error, b_busy, b_error});
    end
  endtask

  task automatic test_basic();
    logic [41:0] exp_a;
    go = 1'b1; tick(); go = 1'b0;
    n_tests++;
    if ({a_busy, a_error} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_go busy/error got %b want 10", {a_busy, a_error});
    end
    in_valid = 1'b1; in_ch = 2'd0;
    in_data = 10'd5;   tick();
    in_data = 10'd900; tick();
    in_data = 10'd17;  tick();
    in_valid = 1'b0;
    finish = 1'b1; tick(); finish = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) exp_a = {1'b1, 2'd0, 10'd5, 10'd900, 10'd895, 8'd3, 1'b0};
      else        exp_a = {1'b1, 2'(k), 10'd0, 10'd0, 10'd0, 8'd0, 1'(k == 3)};
      n_tests++;
      if (a_beat !== exp_a) begin
        n_fail++;
        $display("FAIL basic_a beat%0d got %h want %h", k, a_beat, exp_a);
      end
      if (k == 0) begin
        n_tests++;
        if (b_beat !== {1'b1, 2'd0, 10'd5, 10'd900, 10'd895, 2'd3, 1'b0}) begin
          n_fail++;
          $display("FAIL basic_b beat0 got %h want %h", b_beat, {1'b1, 2'd0, 10'd5, 10'd900, 10'd895, 2'd3, 1'b0});
        end
      end
      tick();
    end
    n_tests++;
    if ({a_busy, a_out_valid, a_out_last, a_out_min} !== 13'd0) begin
      n_fail++;
      $display("FAIL basic_idle got %h want 0", {a_busy, a_out_valid, a_out_last, a_out_min});
    end
  endtask

  task automatic test_finish_same_cycle();
    logic [41:0] exp_a;
    go = 1'b1; tick(); go = 1'b0;
    in_valid = 1'b1; in_ch = 2'd2; in_data = 10'd1023; finish = 1'b1;
    tick();
    in_valid = 1'b0; finish = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) exp_a = {1'b1, 2'd2, 10'd1023, 10'd1023, 10'd0, 8'd1, 1'b0};
      else        exp_a = {1'b1, 2'(k), 10'd0, 10'd0, 10'd0, 8'd0, 1'(k == 3)};
      n_tests++;
      if (a_beat !== exp_a) begin
        n_fail++;
        $display("FAIL samecyc_a beat%0d got %h want %h", k, a_beat, exp_a);
      end
      if (k == 2) begin
        n_tests++;
        if (b_beat !== {1'b1, 2'd2, 10'd1023, 10'd1023, 10'd0, 2'd1, 1'b1}) begin
          n_fail++;
          $display("FAIL samecyc_b beat2 got %h want %h", b_beat, {1'b1, 2'd2, 10'd1023, 10'd1023, 10'd0, 2'd1, 1'b1});
        end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    logic [9:0] vals [5] = '{10'd7, 10'd3, 10'd12, 10'd9, 10'd4};
    go = 1'b1; tick(); go = 1'b0;
    in_valid = 1'b1; in_ch = 2'd1;
    for (int i = 0; i < 5; i++) begin
      in_data = vals[i];
      tick();
    end
    in_valid = 1'b0;
    finish = 1'b1; tick(); finish = 1'b0;
    tick();
    n_tests++;
    if (a_beat !== {1'b1, 2'd1, 10'd3, 10'd12, 10'd9, 8'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_a beat1 got %h want %h", a_beat, {1'b1, 2'd1, 10'd3, 10'd12, 10'd9, 8'd5, 1'b0});
    end
    n_tests++;
    if (b_beat !== {1'b1, 2'd1, 10'd3, 10'd12, 10'd9, 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_b beat1 got %h want %h", b_beat, {1'b1, 2'd1, 10'd3, 10'd12, 10'd9, 2'd3, 1'b0});
    end
    tick(); tick(); tick();
  endtask

  task automatic test_go_finish_idle();
    go = 1'b1; finish = 1'b1; tick(); go = 1'b0; finish = 1'b0;
    n_tests++;
    if ({a_error, a_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL gofin_idle error/busy got %b want 10", {a_error, a_busy});
    end
    go = 1'b1; tick(); go = 1'b0;
    n_tests++;
    if ({a_error, a_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL gofin_rego error/busy got %b want 01", {a_error, a_busy});
    end
    finish = 1'b1; tick(); finish = 1'b0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_valid_in_idle();
    in_valid = 1'b1; in_ch = 2'd0; in_data = 10'd44; tick(); in_valid = 1'b0;
    n_tests++;
    if ({a_error, a_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL idle_valid error/busy got %b want 10", {a_error, a_busy});
    end
  endtask

  task automatic test_bad_channel();
    go = 1'b1; tick(); go = 1'b0;
    n_tests++;
    if ({a_error, b_error} !== 2'b00) begin
      n_fail++;
      $display("FAIL badch_go errors got %b want 00", {a_error, b_error});
    end
    in_valid = 1'b1; in_ch = 2'd3; in_data = 10'd50; tick(); in_valid = 1'b0;
    n_tests++;
    if ({a_error, b_error} !== 2'b01) begin
      n_fail++;
      $display("FAIL badch_flag a/b error got %b want 01", {a_error, b_error});
    end
    finish = 1'b1; tick(); finish = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        n_tests++;
        if (b_beat !== {1'b1, 2'(k), 10'd0, 10'd0, 10'd0, 2'd0, 1'(k == 2)}) begin
          n_fail++;
          $display("FAIL badch_b beat%0d got %h want %h", k, b_beat, {1'b1, 2'(k), 10'd0, 10'd0, 10'd0, 2'd0, 1'(k == 2)});
        end
      end else begin
        n_tests++;
        if (a_beat !== {1'b1, 2'd3, 10'd50, 10'd50, 10'd0, 8'd1, 1'b1}) begin
          n_fail++;
          $display("FAIL badch_a beat3 got %h want %h", a_beat, {1'b1, 2'd3, 10'd50, 10'd50, 10'd0, 8'd1, 1'b1});
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_report();
    go = 1'b1; tick(); go = 1'b0;
    in_valid = 1'b1; in_ch = 2'd0; in_data = 10'd100; tick(); in_valid = 1'b0;
    finish = 1'b1; tick(); finish = 1'b0;
    tick();
    n_tests++;
    if ({a_out_valid, a_out_ch} !== 3'b101) begin
      n_fail++;
      $display("FAIL rstmid_pre valid/ch got %b want 101", {a_out_valid, a_out_ch});
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({a_out_valid, a_busy, a_error, b_out_valid, b_busy} !== 5'b00000) begin
      n_fail++;
      $display("FAIL rstmid_async flags got %b want 00000", {a_out_valid, a_busy, a_error, b_out_valid, b_busy});
    end
    n_tests++;
    if (a_beat !== 42'd0) begin
      n_fail++;
      $display("FAIL rstmid_beat got %h want 0", a_beat);
    end
    tick();
    reset_n = 1'b1;
    tick();
    n_tests++;
    if ({a_busy, a_out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_release busy/valid got %b want 00", {a_busy, a_out_valid});
    end
    go = 1'b1; tick(); go = 1'b0;
    finish = 1'b1; tick(); finish = 1'b0;
    n_tests++;
    if (a_beat !== {1'b1, 2'd0, 10'd0, 10'd0, 10'd0, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_empty beat0 got %h want %h", a_beat, {1'b1, 2'd0, 10'd0, 10'd0, 10'd0, 8'd0, 1'b0});
    end
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_finish_same_cycle();
    test_saturation();
    test_go_finish_idle();
    test_valid_in_idle();
    test_bad_channel();
    test_reset_mid_report();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
